// File: rtl/fetch_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module  : fetch_sequencer_if
// Purpose : Instruction-memory fetch bus between the fetch sequencer and
//           instruction memory.
// Signals : memReq   - fetch request (master -> slave)
//           memAddr  - fetch address (master -> slave)
//           memReady - response valid (slave -> master)
//           memData  - response word  (slave -> master)
// Modports: master (fetch sequencer side), slave (memory side)
// Revision: 1.0 - initial release
// ============================================================================
interface fetch_sequencer_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16
) ();

  logic                  memReq;
  logic [ADDR_WIDTH-1:0] memAddr;
  logic                  memReady;
  logic [DATA_WIDTH-1:0] memData;

  modport master (
    output memReq,
    output memAddr,
    input  memReady,
    input  memData
  );

  modport slave (
    input  memReq,
    input  memAddr,
    output memReady,
    output memData
  );

endinterface
`default_nettype wire

// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : fetch_sequencer
// Purpose : Instruction-fetch stage feeding the instruction-register latch.
//           Owns the PC, runs a request/ready handshake with instruction
//           memory, captures each returned word and pulses the latch enable
//           for one cycle. Supports stall holds, branch redirects that squash
//           any in-flight response, and silent PC wrap-around.
// Ports   : clk          - clock, rising edge
//           resetN       - asynchronous active-low reset
//           stall        - downstream hold (keeps current instruction)
//           branchTaken  - redirect pulse, highest priority
//           branchTarget - redirect address
//           mem          - instruction memory bus (master modport)
//           latchInput   - captured instruction word
//           latchEnable  - one-cycle load pulse for the latch
//           instrValid   - latchInput holds a live instruction
//           pc           - address of the next fetch
//           fetchError   - sticky fetch timeout flag
// Config  : define FETCH_TIMEOUT_EN to build the FETCH wait timeout; without
//           it FETCH waits indefinitely and fetchError is tied low.
// Revision: 1.0 - initial release
// ============================================================================
module fetch_sequencer #(
  parameter int ADDR_WIDTH     = 16,
  parameter int DATA_WIDTH     = 16,
  parameter int RESET_PC       = 0,
  parameter int PC_STEP        = 1,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  wire logic                  clk,
  input  wire logic                  resetN,
  input  wire logic                  stall,
  input  wire logic                  branchTaken,
  input  wire logic [ADDR_WIDTH-1:0] branchTarget,
  fetch_sequencer_if.master          mem,
  output logic      [DATA_WIDTH-1:0] latchInput,
  output logic                       latchEnable,
  output logic                       instrValid,
  output logic      [ADDR_WIDTH-1:0] pc,
  output logic                       fetchError
);

  typedef enum logic [1:0] {
    FLUSH = 2'd0,
    FETCH = 2'd1,
    ISSUE = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_nextState;
  logic [ADDR_WIDTH-1:0] r_pc;
  logic [ADDR_WIDTH-1:0] w_nextPc;
  logic [DATA_WIDTH-1:0] r_latch;
  logic [DATA_WIDTH-1:0] w_nextLatch;
  logic                  r_valid;
  logic                  w_nextValid;
  logic                  r_enable;
  logic                  w_nextEnable;
  logic                  w_timeout;

  // Request is a pure decode of the state register so that an asynchronous
  // reset (state -> FLUSH) drops it immediately.
  assign mem.memReq  = (r_state == FETCH);
  assign mem.memAddr = r_pc;

  assign latchInput  = r_latch;
  assign latchEnable = r_enable;
  assign instrValid  = r_valid;
  assign pc          = r_pc;

  // --------------------------------------------------------------------------
  // Next-state / next-value logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_nextState  = r_state;
    w_nextPc     = r_pc;
    w_nextLatch  = r_latch;
    w_nextValid  = r_valid;
    w_nextEnable = 1'b0;   // enable is a single-cycle pulse

    case (r_state)
      FLUSH: begin
        // memReady is deliberately ignored here.
        w_nextState = FETCH;
      end
      FETCH: begin
        if (mem.memReady) begin
          w_nextLatch  = mem.memData;
          w_nextValid  = 1'b1;
          w_nextEnable = 1'b1;
          // Truncation to ADDR_WIDTH gives the intended silent wrap.
          w_nextPc     = r_pc + ADDR_WIDTH'(PC_STEP);
          w_nextState  = ISSUE;
        end else if (w_timeout) begin
          // Retry the same address after a flush cycle.
          w_nextState = FLUSH;
        end
      end
      ISSUE: begin
        if (!stall) begin
          w_nextState = FETCH;
        end
      end
      default: begin
        w_nextState = FLUSH;
      end
    endcase

    // Redirect overrides everything, including a same-cycle response.
    if (branchTaken) begin
      w_nextPc     = branchTarget;
      w_nextValid  = 1'b0;
      w_nextEnable = 1'b0;
      w_nextLatch  = r_latch;
      w_nextState  = FLUSH;
    end
  end

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_state  <= FLUSH;
      r_pc     <= ADDR_WIDTH'(RESET_PC);
      r_latch  <= '0;
      r_valid  <= 1'b0;
      r_enable <= 1'b0;
    end else begin
      r_state  <= w_nextState;
      r_pc     <= w_nextPc;
      r_latch  <= w_nextLatch;
      r_valid  <= w_nextValid;
      r_enable <= w_nextEnable;
    end
  end

  // --------------------------------------------------------------------------
  // Optional FETCH wait timeout
  // --------------------------------------------------------------------------
`ifdef FETCH_TIMEOUT_EN
  localparam int c_CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 4) ?
                           $clog2(TIMEOUT_CYCLES + 1) : 4;

  logic [c_CNT_W-1:0] r_waitCnt;
  logic               r_error;

  // Fires in the TIMEOUT_CYCLES-th consecutive FETCH cycle without a response.
  assign w_timeout = (r_state == FETCH) && !mem.memReady &&
                     (r_waitCnt == c_CNT_W'(TIMEOUT_CYCLES - 1));
  assign fetchError = r_error;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_waitCnt <= '0;
      r_error   <= 1'b0;
    end else begin
      // Held at zero outside FETCH, so every entry to FETCH starts clean.
      if (r_state != FETCH) begin
        r_waitCnt <= '0;
      end else if (!mem.memReady) begin
        r_waitCnt <= r_waitCnt + 1'b1;
      end
      if (w_timeout) begin
        r_error <= 1'b1;
      end
    end
  end
`else
  logic [31:0] w_unusedTimeoutCfg;

  assign w_unusedTimeoutCfg = 32'(TIMEOUT_CYCLES);
  assign w_timeout          = 1'b0;
  assign fetchError         = 1'b0;
`endif

endmodule
`default_nettype wire
